// File: rtl/rv_pkg.sv
// Shared register-file defaults and dump engine state encodings.
package rv_pkg;
    localparam int XLEN_DEF = 32;
    localparam int NREG_DEF = 32;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } dump_st_e;
endpackage

// File: rtl/regfile_dump_fsm.sv
// Dump engine: walks a register range and presents one snapshot entry
// per cycle over a valid/ready port.
module regfile_dump_fsm
    import rv_pkg::*;
#(
    parameter int XLEN = XLEN_DEF,
    parameter int NREG = NREG_DEF,
    localparam int AW = $clog2(NREG)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [AW-1:0]   first,
    input  logic [AW:0]     count,
    input  logic            ready,
    input  logic [XLEN-1:0] rd_data,
    output logic [AW-1:0]   rd_addr,
    output logic            valid,
    output logic [AW-1:0]   idx,
    output logic [XLEN-1:0] data,
    output logic            last,
    output logic            busy,
    output logic            err
);
    localparam logic [AW:0] NREG_C = (AW+1)'(NREG);
    localparam logic [AW:0] ONE_C  = (AW+1)'(1);

    dump_st_e        state_q, state_d;
    logic [AW-1:0]   idx_q, idx_d;
    logic [XLEN-1:0] data_q, data_d;
    logic [AW:0]     rem_q, rem_d;
    logic            err_q, err_d;
    logic [AW-1:0]   nxt_idx;
    logic [AW:0]     cnt_eff;
    logic            first_ok;

    always_comb begin
        nxt_idx  = (idx_q == AW'(NREG - 1)) ? '0 : idx_q + 1'b1;
        cnt_eff  = (count == '0 || count > NREG_C) ? NREG_C : count;
        first_ok = {1'b0, first} < NREG_C;
        state_d  = state_q;
        idx_d    = idx_q;
        data_d   = data_q;
        rem_d    = rem_q;
        err_d    = 1'b0;
        // In RUN the array is pre-read at the next index so a handshake
        // can capture the following entry on the same edge.
        rd_addr  = (state_q == ST_RUN) ? nxt_idx : first;
        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    if (first_ok) begin
                        state_d = ST_RUN;
                        idx_d   = first;
                        data_d  = rd_data;
                        rem_d   = cnt_eff;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            ST_RUN: begin
                if (ready) begin
                    if (rem_q == ONE_C) begin
                        state_d = ST_IDLE;
                    end else begin
                        idx_d  = nxt_idx;
                        data_d = rd_data;
                        rem_d  = rem_q - ONE_C;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            data_q  <= '0;
            rem_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            data_q  <= data_d;
            rem_q   <= rem_d;
            err_q   <= err_d;
        end
    end

    assign valid = (state_q == ST_RUN);
    assign busy  = (state_q == ST_RUN);
    assign last  = valid && (rem_q == ONE_C);
    assign idx   = idx_q;
    assign data  = data_q;
    assign err   = err_q;
endmodule

// File: rtl/regfile_scan.sv
// RISC-V integer register file with NRD read ports, one write port,
// optional write-through bypass and a streaming dump engine.
module regfile_scan
    import rv_pkg::*;
#(
    parameter int XLEN   = XLEN_DEF,
    parameter int NREG   = NREG_DEF,
    parameter int NRD    = 2,
    parameter int BYPASS = 1,
    localparam int AW = $clog2(NREG)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [AW-1:0]     waddr,
    input  logic [XLEN-1:0]   wdata,
    input  logic [NRD*AW-1:0] raddr,
    output logic [NRD*XLEN-1:0] rdata,
    input  logic              dump_start,
    input  logic [AW-1:0]     dump_first,
    input  logic [AW:0]       dump_count,
    output logic              dump_valid,
    input  logic              dump_ready,
    output logic [AW-1:0]     dump_idx,
    output logic [XLEN-1:0]   dump_data,
    output logic              dump_last,
    output logic              dump_busy,
    output logic              dump_err
);
    localparam logic [AW:0] NREG_C = (AW+1)'(NREG);

    logic [XLEN-1:0] regs_q [NREG];
    logic [XLEN-1:0] regs_d [NREG];
    logic            wr_en;
    logic [AW-1:0]   dmp_addr;
    logic [XLEN-1:0] dmp_data;

    function automatic logic in_rng(input logic [AW-1:0] a);
        return (a != '0) && ({1'b0, a} < NREG_C);
    endfunction

    // x0 and out-of-range addresses read as zero.
    function automatic logic [XLEN-1:0] rd_val(input logic [AW-1:0] a);
        if (!in_rng(a))
            return '0;
        if (BYPASS != 0 && wr_en && waddr == a)
            return wdata;
        return regs_q[a];
    endfunction

    assign wr_en = we && in_rng(waddr);

    always_comb begin
        for (int k = 0; k < NREG; k++)
            regs_d[k] = regs_q[k];
        if (wr_en)
            regs_d[waddr] = wdata;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int k = 0; k < NREG; k++)
                regs_q[k] <= '0;
        end else begin
            for (int k = 0; k < NREG; k++)
                regs_q[k] <= regs_d[k];
        end
    end

    always_comb begin
        rdata = '0;
        for (int i = 0; i < NRD; i++)
            rdata[i*XLEN +: XLEN] = rd_val(raddr[i*AW +: AW]);
        dmp_data = rd_val(dmp_addr);
    end

    regfile_dump_fsm #(
        .XLEN (XLEN),
        .NREG (NREG)
    ) u_dump (
        .clk     (clk),
        .rst     (rst),
        .start   (dump_start),
        .first   (dump_first),
        .count   (dump_count),
        .ready   (dump_ready),
        .rd_data (dmp_data),
        .rd_addr (dmp_addr),
        .valid   (dump_valid),
        .idx     (dump_idx),
        .data    (dump_data),
        .last    (dump_last),
        .busy    (dump_busy),
        .err     (dump_err)
    );
endmodule
